// File: rtl/div_sequencer.sv
// Request/response front end for the 16-bit restoring divider: sign handling,
// divider start/done sequencing and local divide-by-zero resolution.
module div_sequencer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_dividend,
  input  logic [W-1:0] req_divisor,
  input  logic         req_signed,
  output logic         div_start,
  output logic [W-1:0] div_dividend,
  output logic [W-1:0] div_divisor,
  input  logic         div_done,
  input  logic [W-1:0] div_quotient,
  input  logic [W-1:0] div_remainder,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_quotient,
  output logic [W-1:0] rsp_remainder,
  output logic         rsp_div0,
  output logic         rsp_overflow
);

  // state   | meaning
  // IDLE    | ready for a request
  // ISSUE   | Start held high, waiting for the divider's Done
  // RELEASE | Start dropped, waiting for Done to fall
  // RESP    | result presented until consumer accepts it
  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, RESP} state_t;

  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  state_t state, state_nxt;
  logic   neg_q, neg_r, ovf_pend;
  logic   accept, zero_div;

  assign accept   = (state == IDLE) && req_valid;
  assign zero_div = (req_divisor == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = zero_div ? RESP : ISSUE;
      ISSUE:   if (div_done)  state_nxt = RELEASE;
      RELEASE: if (!div_done) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign div_start = (state == ISSUE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_dividend  <= '0;
      div_divisor   <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      ovf_pend      <= 1'b0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_div0      <= 1'b0;
      rsp_overflow  <= 1'b0;
    end else if (accept) begin
      // 0x8000 negates to itself, which is exactly the unsigned magnitude 32768
      div_dividend <= (req_signed && req_dividend[W-1]) ? (~req_dividend + ONE) : req_dividend;
      div_divisor  <= (req_signed && req_divisor[W-1])  ? (~req_divisor + ONE)  : req_divisor;
      neg_q        <= req_signed & (req_dividend[W-1] ^ req_divisor[W-1]);
      neg_r        <= req_signed & req_dividend[W-1];
      ovf_pend     <= req_signed && (req_dividend == MINV) && (req_divisor == '1);
      if (zero_div) begin
        rsp_quotient  <= '1;
        rsp_remainder <= req_dividend;
        rsp_div0      <= 1'b1;
        rsp_overflow  <= 1'b0;
      end
    end else if ((state == ISSUE) && div_done) begin
      rsp_div0     <= 1'b0;
      rsp_overflow <= ovf_pend;
      if (ovf_pend) begin
        rsp_quotient  <= MINV;
        rsp_remainder <= '0;
      end else begin
        rsp_quotient  <= neg_q ? (~div_quotient + ONE)  : div_quotient;
        rsp_remainder <= neg_r ? (~div_remainder + ONE) : div_remainder;
      end
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a behavioural restoring-divider stand-in.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_dividend = '0;
  logic [15:0] req_divisor = '0;
  logic        req_signed = 1'b0;
  logic        div_start;
  logic [15:0] div_dividend, div_divisor;
  logic        div_done;
  logic [15:0] div_quotient, div_remainder;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_quotient, rsp_remainder;
  logic        rsp_div0, rsp_overflow;

  int errors = 0;
  int checks = 0;

  div_sequencer #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .req_signed(req_signed),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_div0(rsp_div0), .rsp_overflow(rsp_overflow)
  );

  always #5 clk = ~clk;

  // Divider stand-in: Done 3 cycles after Start, held one extra cycle after Start drops
  logic       busy, extra;
  logic [2:0] cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 0; extra <= 0; cnt <= 0; div_done <= 0;
      div_quotient <= 0; div_remainder <= 0;
    end else if (div_done) begin
      if (!div_start) begin
        if (extra) begin div_done <= 0; extra <= 0; end
        else extra <= 1;
      end
    end else if (busy) begin
      cnt <= cnt - 3'd1;
      if (cnt == 3'd1) begin
        busy <= 0;
        div_done <= 1;
        div_quotient  <= (div_divisor != 0) ? div_dividend / div_divisor : 16'hFFFF;
        div_remainder <= (div_divisor != 0) ? div_dividend % div_divisor : div_dividend;
      end
    end else if (div_start) begin
      busy <= 1; cnt <= 3'd3;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [15:0] eq, input logic [15:0] er,
                        input logic ed0, input logic eov, input logic [15:0] eda,
                        input logic [15:0] edb, input int bp);
    int n;
    logic [15:0] q0, r0;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, " idle timeout"}, 32'(n < 50), 1);
    req_dividend = a; req_divisor = b; req_signed = s; req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    if (b == 0) begin
      check({tag, " div0 start"}, div_start, 0);
      check({tag, " div0 valid T+1"}, rsp_valid, 1);
    end else begin
      check({tag, " start T+1"}, div_start, 1);
      check({tag, " div_dividend"}, div_dividend, eda);
      check({tag, " div_divisor"}, div_divisor, edb);
      n = 0;
      while (!div_done && n < 50) begin @(negedge clk); n++; end
      check({tag, " done timeout"}, 32'(n < 50), 1);
      check({tag, " start at done"}, div_start, 1);
      @(negedge clk);
      check({tag, " start after done"}, div_start, 0);
      check({tag, " valid early"}, rsp_valid, 0);
      n = 0;
      while (div_done && n < 50) begin @(negedge clk); n++; end
      check({tag, " release timeout"}, 32'(n < 50), 1);
      check({tag, " valid before release"}, rsp_valid, 0);
      @(negedge clk);
      check({tag, " valid after release"}, rsp_valid, 1);
    end
    check({tag, " quotient"}, rsp_quotient, eq);
    check({tag, " remainder"}, rsp_remainder, er);
    check({tag, " div0"}, rsp_div0, ed0);
    check({tag, " overflow"}, rsp_overflow, eov);
    q0 = rsp_quotient; r0 = rsp_remainder;
    for (int i = 0; i < bp; i++) begin
      req_valid = (i == 1);
      req_dividend = 16'h0009; req_divisor = 16'h0003; req_signed = 0;
      @(negedge clk);
      check({tag, " bp valid"}, rsp_valid, 1);
      check({tag, " bp req_ready"}, req_ready, 0);
      check({tag, " bp stable"}, {rsp_quotient, rsp_remainder}, {q0, r0});
    end
    req_valid = 0;
    rsp_ready = 1;
    @(posedge clk); #1 rsp_ready = 0;
    @(negedge clk);
    check({tag, " ready after hs"}, req_ready, 1);
    check({tag, " valid after hs"}, rsp_valid, 0);
  endtask

  initial begin
    int n;
    #12;
    check("reset req_ready", req_ready, 1);
    check("reset start", div_start, 0);
    check("reset valid", rsp_valid, 0);
    check("reset operands", {div_dividend, div_divisor}, 0);
    check("reset results", {rsp_quotient, rsp_remainder}, 0);
    check("reset flags", {rsp_div0, rsp_overflow}, 0);
    @(negedge clk); rst_n = 1;

    run_op("u100/7",   16'd100,  16'd7,    0, 16'd14,   16'd2,    0, 0, 16'd100,  16'd7, 0);
    run_op("s-100/7",  16'hFF9C, 16'h0007, 1, 16'hFFF2, 16'hFFFE, 0, 0, 16'd100,  16'd7, 0);
    run_op("s100/-7",  16'h0064, 16'hFFF9, 1, 16'hFFF2, 16'h0002, 0, 0, 16'd100,  16'd7, 0);
    run_op("ovf",      16'h8000, 16'hFFFF, 1, 16'h8000, 16'h0000, 0, 1, 16'h8000, 16'd1, 0);
    run_op("u_ffff/16",16'hFFFF, 16'h0010, 0, 16'h0FFF, 16'h000F, 0, 0, 16'hFFFF, 16'h0010, 0);
    run_op("div0",     16'h04D2, 16'h0000, 0, 16'hFFFF, 16'h04D2, 1, 0, 16'h0000, 16'h0000, 0);
    run_op("bp 45/6",  16'd45,   16'd6,    0, 16'd7,    16'd3,    0, 0, 16'd45,   16'd6, 5);

    // reset asserted while the divider is running
    req_dividend = 16'h1234; req_divisor = 16'd3; req_signed = 0; req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
    n = 0;
    @(negedge clk);
    while (!div_start && n < 20) begin @(negedge clk); n++; end
    check("rst issue reached", div_start, 1);
    #1 rst_n = 0;
    #1;
    check("rst start", div_start, 0);
    check("rst req_ready", req_ready, 1);
    check("rst valid", rsp_valid, 0);
    check("rst operands", {div_dividend, div_divisor}, 0);
    check("rst results", {rsp_quotient, rsp_remainder, 14'd0, rsp_div0, rsp_overflow}, 0);
    @(negedge clk); rst_n = 1;
    run_op("post-rst 50/5", 16'd50, 16'd5, 0, 16'd10, 16'd0, 0, 0, 16'd50, 16'd5, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Request/response front end for the 16-bit restoring divider (RD). It accepts one divide request at a time over a valid/ready handshake and converts signed operands to magnitudes. It drives the divider's Start/operand inputs, waits for Done, restores result signs, and returns quotient, remainder and status over a second valid/ready handshake. Divide-by-zero is resolved locally without starting the divider.

## Interface
Parameters:
- W, 16, operand/result width; must match the divider's 16-bit datapath.

Ports:
- Clock  in  1  system clock; all state changes on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Req_Valid  in  1  request present.
- Req_Ready  out  1  sequencer can accept a request; high only in IDLE.
- Req_Dividend  in  W  dividend.
- Req_Divisor  in  W  divisor.
- Req_Signed  in  1  1 = two's-complement operands; 0 = unsigned.
- Div_Start  out  1  to divider Start.
- Div_Dividend  out  W  to divider Dividend; operand magnitude.
- Div_Divisor  out  W  to divider Divisor; operand magnitude.
- Div_Done  in  1  from divider Done.
- Div_Quotient  in  W  from divider Quotient; unsigned.
- Div_Remainder  in  W  from divider Remainder; unsigned.
- Rsp_Valid  out  1  result available.
- Rsp_Ready  in  1  consumer accepts result.
- Rsp_Quotient  out  W  final quotient.
- Rsp_Remainder  out  W  final remainder.
- Rsp_Div0  out  1  divisor was zero.
- Rsp_Overflow  out  1  signed 0x8000 / 0xFFFF.

## Operation
- States: IDLE, ISSUE, RELEASE, RESP.
- IDLE: Req_Ready=1. On Req_Valid, capture operands, Req_Signed, neg_q and neg_r.
  - neg_q = Req_Signed & (dividend[15] ^ divisor[15]).
  - neg_r = Req_Signed & dividend[15].
  - Magnitudes: when Req_Signed=1 and the MSB is set, use the two's complement; otherwise pass the operand through. 0x8000 maps to 0x8000 (unsigned 32768).
  - If divisor == 0, go to RESP: Quotient = 0xFFFF, Remainder = raw Req_Dividend, Div0 = 1, Overflow = 0.
  - Else go to ISSUE.
- ISSUE: Div_Start=1; Div_Dividend/Div_Divisor hold the registered magnitudes.
  - On the first cycle Div_Done=1, register the results:
    - Quotient = neg_q ? −Div_Quotient : Div_Quotient.
    - Remainder = neg_r ? −Div_Remainder : Div_Remainder.
    - Overflow = Req_Signed & dividend==0x8000 & divisor==0xFFFF; quotient wraps to 0x8000 and remainder is 0.
  - Then go to RELEASE.
- RELEASE: Div_Start=0. Wait for Div_Done=0, then go to RESP. The divider holds Done one extra cycle after Start drops, so re-issue before Done falls is forbidden.
- RESP: Rsp_Valid=1 with the registered results. On Rsp_Ready=1, go to IDLE.
- Arithmetic: negation is W-bit two's complement, modulo 2^W. No result register is wider than W.

## Timing
- Reset values (asynchronous on Reset_n=0, held until release):
  - state = IDLE.
  - Req_Ready = 1.
  - Div_Start = 0.
  - Div_Dividend = Div_Divisor = 0.
  - Rsp_Valid = 0.
  - Rsp_Quotient = Rsp_Remainder = 0.
  - Rsp_Div0 = Rsp_Overflow = 0.
- All outputs are registered or decoded from state only. No combinational path from Req_*, Div_* or Rsp_Ready to any output.
- Request accepted at edge T (Req_Valid & Req_Ready).
  - Normal path: Div_Start=1 from T+1. Result registered at the edge where Div_Done=1 is sampled (edge D). Div_Start=0 from D+1. Rsp_Valid=1 from the cycle after Div_Done is sampled 0.
  - Div0 path: Rsp_Valid=1 from T+1; Div_Start stays 0.
- Rsp_Valid stays high and Rsp_* stay stable until the Rsp_Ready handshake. Req_Ready returns to 1 the cycle after the handshake, so there is no same-cycle response/request overlap.
- Req_Valid outside IDLE is ignored; operands are not sampled.
- Reset asserted mid-operation returns to reset values immediately and drops Div_Start. Any pending result is discarded. The divider is reset from the same system reset at top level.
- A Div_Done pulse while in IDLE or RESP is ignored.

## Test plan
- Unsigned 100/7 (Req_Signed=0) -> Rsp_Quotient=14, Rsp_Remainder=2, Div0=0, Overflow=0. Div_Start deasserts the cycle after Done is seen. Rsp_Valid rises only after Div_Done falls.
- Signed −100/7 (0xFF9C/0x0007) -> Div_Dividend=100, Div_Divisor=7; Rsp_Quotient=0xFFF2, Rsp_Remainder=0xFFFE. Signed 100/−7 -> Rsp_Quotient=0xFFF2, Rsp_Remainder=0x0002.
- Signed 0x8000/0xFFFF -> Div_Dividend=0x8000, Div_Divisor=1; Rsp_Quotient=0x8000, Rsp_Remainder=0, Rsp_Overflow=1.
- Divide by zero 1234/0 -> Div_Start never asserts; Rsp_Valid at T+1 with Quotient=0xFFFF, Remainder=0x04D2, Div0=1.
- Backpressure: Rsp_Ready held 0 for 5 cycles after Rsp_Valid -> Rsp_* stable and Req_Ready=0 throughout. A Req_Valid pulse during this window is not accepted. Req_Ready=1 the cycle after the handshake.
- Reset_n pulsed low during ISSUE -> all outputs at reset values the same cycle, Div_Start=0. A new 50/5 request after reset returns Quotient=10, Remainder=0.
